// File: rtl/word_align_ctl.sv
// rtl/word_align_ctl.sv - word-boundary alignment controller for the LVDS 7:1 receive path
// Slips the deserializer until the clock-lane word matches RX_CLK_PT, then watches for loss.
module word_align_ctl #(
    parameter logic [6:0] RX_CLK_PT  = 7'b1100011,
    parameter int         SETTLE_CYC = 16,
    parameter int         CHECK_CYC  = 64,
    parameter int         LOSS_TH    = 8
) (
    input  logic       rx_clk,
    input  logic       reset,
    input  logic [6:0] rxclk_word,
    input  logic       dphase_lock,
    output logic       O_bitslip,
    output logic [2:0] O_slip_cnt,
    output logic       O_word_lock,
    output logic       O_realign_req,
    output logic [7:0] O_loss_cnt
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        CHECK  = 3'd2,
        SLIP   = 3'd3,
        LOCK   = 3'd4,
        FAIL   = 3'd5
    } state_t;

    localparam logic [9:0]  SETTLE_LAST = 10'(SETTLE_CYC - 1);
    localparam logic [9:0]  CHECK_LAST  = 10'(CHECK_CYC - 1);
    localparam logic [7:0]  RUN_LAST    = 8'(LOSS_TH - 1);
    localparam logic [2:0]  SLIP_MAX    = 3'd6;
    localparam logic [10:0] MISS_SAT    = 11'h7ff;
    localparam logic [7:0]  LOSS_SAT    = 8'hff;

    state_t      state;
    state_t      state_nxt;
    logic [9:0]  wait_cnt;
    logic [10:0] miss_cnt;
    logic [10:0] miss_nxt;
    logic [7:0]  run_cnt;
    logic        mismatch;
    logic        loss_event;

    assign mismatch = (rxclk_word != RX_CLK_PT);

    // The last window sample must be folded in before deciding LOCK vs SLIP.
    assign miss_nxt = (mismatch && miss_cnt != MISS_SAT) ? miss_cnt + 11'd1 : miss_cnt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (dphase_lock) state_nxt = SETTLE;
            SETTLE:  if (wait_cnt == SETTLE_LAST) state_nxt = CHECK;
            CHECK: begin
                if (wait_cnt == CHECK_LAST) begin
                    if (miss_nxt == 11'd0)         state_nxt = LOCK;
                    else if (O_slip_cnt == SLIP_MAX) state_nxt = FAIL;
                    else                             state_nxt = SLIP;
                end
            end
            SLIP:    state_nxt = SETTLE;
            LOCK:    if (mismatch && run_cnt == RUN_LAST) state_nxt = IDLE;
            FAIL:    if (!dphase_lock) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Losing bit-phase lock overrides everything; FAIL already exits on it above.
        if (!dphase_lock && state != FAIL) state_nxt = IDLE;
    end

    assign loss_event = (state == LOCK) && (state_nxt == IDLE) && dphase_lock;

    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            wait_cnt      <= 10'd0;
            miss_cnt      <= 11'd0;
            run_cnt       <= 8'd0;
            O_bitslip     <= 1'b0;
            O_slip_cnt    <= 3'd0;
            O_word_lock   <= 1'b0;
            O_realign_req <= 1'b0;
            O_loss_cnt    <= 8'd0;
        end else begin
            state         <= state_nxt;
            O_bitslip     <= (state_nxt == SLIP);
            O_word_lock   <= (state_nxt == LOCK);
            O_realign_req <= (state_nxt == FAIL);

            if (state_nxt != state)
                wait_cnt <= 10'd0;
            else if (state == SETTLE || state == CHECK)
                wait_cnt <= wait_cnt + 10'd1;

            if (state == CHECK && state_nxt == CHECK)
                miss_cnt <= miss_nxt;
            else
                miss_cnt <= 11'd0;

            if (state == LOCK && state_nxt == LOCK)
                run_cnt <= mismatch ? run_cnt + 8'd1 : 8'd0;
            else
                run_cnt <= 8'd0;

            if (state_nxt == IDLE)
                O_slip_cnt <= 3'd0;
            else if (state == SLIP)
                O_slip_cnt <= O_slip_cnt + 3'd1;

            if (loss_event && O_loss_cnt != LOSS_SAT)
                O_loss_cnt <= O_loss_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_word_align_ctl.sv
// tb/tb_word_align_ctl.sv - directed self-checking bench for word_align_ctl
module tb_word_align_ctl;

    localparam logic [6:0] PAT = 7'b1100011;

    logic       rx_clk = 1'b0;
    logic       reset;
    logic [6:0] rxclk_word;
    logic       dphase_lock;
    logic       O_bitslip;
    logic [2:0] O_slip_cnt;
    logic       O_word_lock;
    logic       O_realign_req;
    logic [7:0] O_loss_cnt;

    word_align_ctl dut (
        .rx_clk        (rx_clk),
        .reset         (reset),
        .rxclk_word    (rxclk_word),
        .dphase_lock   (dphase_lock),
        .O_bitslip     (O_bitslip),
        .O_slip_cnt    (O_slip_cnt),
        .O_word_lock   (O_word_lock),
        .O_realign_req (O_realign_req),
        .O_loss_cnt    (O_loss_cnt)
    );

    always #5 rx_clk = ~rx_clk;

    int         errors = 0;
    int         checks = 0;
    int         rot = 0;
    int         pulses = 0;
    int         wide = 0;
    logic       prev_bs = 1'b0;
    logic       force_on = 1'b0;
    logic [6:0] force_word = 7'd0;
    int         n;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] rotl(input logic [6:0] w, input int r);
        logic [6:0] t;
        t = w;
        for (int i = 0; i < r; i++) t = {t[5:0], t[6]};
        return t;
    endfunction

    task automatic drive_word();
        rxclk_word = force_on ? force_word : rotl(PAT, rot);
    endtask

    // Deserializer model: each observed pulse rotates the source by one bit.
    task automatic step();
        @(posedge rx_clk);
        #1;
        if (O_bitslip) begin
            if (prev_bs) wide++;
            pulses++;
            rot = (rot + 1) % 7;
        end
        prev_bs = O_bitslip;
        drive_word();
    endtask

    // which: 0 = word_lock, 1 = realign_req, 2 = bitslip
    task automatic run_until(input int which, input int budget, output int cnt);
        logic hit;
        cnt = 0;
        hit = 1'b0;
        while (!hit && cnt < budget) begin
            step();
            cnt++;
            hit = (which == 0) ? O_word_lock : (which == 1) ? O_realign_req : O_bitslip;
        end
    endtask

    initial begin
        reset = 1'b1;
        dphase_lock = 1'b0;
        drive_word();
        #3;
        check("rst_bitslip", O_bitslip, 0);
        check("rst_slip_cnt", O_slip_cnt, 0);
        check("rst_word_lock", O_word_lock, 0);
        check("rst_realign", O_realign_req, 0);
        check("rst_loss_cnt", O_loss_cnt, 0);
        @(negedge rx_clk);
        reset = 1'b0;
        step();
        step();

        // No slip needed
        pulses = 0;
        dphase_lock = 1'b1;
        run_until(0, 2000, n);
        check("noslip_latency", n, 81);
        check("noslip_pulses", pulses, 0);
        check("noslip_slip_cnt", O_slip_cnt, 0);

        // Loss of lock: 7 bad, 1 good, 8 bad
        force_on = 1'b1;
        force_word = 7'd0;
        drive_word();
        repeat (7) step();
        check("loss_burst7_lock", O_word_lock, 1);
        check("loss_burst7_cnt", O_loss_cnt, 0);
        force_on = 1'b0;
        drive_word();
        step();
        force_on = 1'b1;
        drive_word();
        repeat (7) step();
        check("loss_run7_lock", O_word_lock, 1);
        step();
        check("loss_run8_lock", O_word_lock, 0);
        check("loss_run8_cnt", O_loss_cnt, 1);
        force_on = 1'b0;
        drive_word();
        run_until(0, 2000, n);
        check("relock_latency", n, 81);
        check("relock_pulses", pulses, 0);

        // Lock dropped together with a bad word: not a loss event
        force_on = 1'b1;
        drive_word();
        dphase_lock = 1'b0;
        step();
        check("drop_lock_word_lock", O_word_lock, 0);
        check("drop_lock_loss_cnt", O_loss_cnt, 1);
        force_on = 1'b0;
        step();

        // Rotated by 3: four slips
        rot = 3;
        pulses = 0;
        wide = 0;
        drive_word();
        dphase_lock = 1'b1;
        run_until(0, 3000, n);
        check("rot3_latency", n, 405);
        check("rot3_pulses", pulses, 4);
        check("rot3_wide", wide, 0);
        check("rot3_slip_cnt", O_slip_cnt, 4);
        dphase_lock = 1'b0;
        step();
        check("rot3_drop_slip_cnt", O_slip_cnt, 0);
        check("rot3_drop_lock", O_word_lock, 0);

        // Single miss on the last CHECK cycle, then abort mid-CHECK
        rot = 0;
        pulses = 0;
        drive_word();
        dphase_lock = 1'b1;
        repeat (80) step();
        check("miss_pre_bitslip", O_bitslip, 0);
        force_on = 1'b1;
        force_word = 7'b1100001;
        drive_word();
        step();
        check("miss_last_bitslip", O_bitslip, 1);
        check("miss_last_lock", O_word_lock, 0);
        force_on = 1'b0;
        drive_word();
        step();
        check("miss_slip_cnt", O_slip_cnt, 1);
        check("miss_pulse_width", O_bitslip, 0);
        repeat (40) step();
        dphase_lock = 1'b0;
        step();
        check("abort_slip_cnt", O_slip_cnt, 0);
        check("abort_bitslip", O_bitslip, 0);
        check("abort_lock", O_word_lock, 0);
        step();

        // Exhaustion
        force_on = 1'b1;
        force_word = 7'd0;
        pulses = 0;
        wide = 0;
        drive_word();
        dphase_lock = 1'b1;
        run_until(1, 4000, n);
        check("exh_latency", n, 567);
        check("exh_pulses", pulses, 6);
        check("exh_slip_cnt", O_slip_cnt, 6);
        check("exh_lock", O_word_lock, 0);
        repeat (5) step();
        check("exh_hold_realign", O_realign_req, 1);
        check("exh_hold_pulses", pulses, 6);
        dphase_lock = 1'b0;
        step();
        check("exh_exit_realign", O_realign_req, 0);
        check("exh_exit_slip_cnt", O_slip_cnt, 0);
        step();

        // Asynchronous reset during the SLIP cycle
        force_on = 1'b0;
        rot = 3;
        drive_word();
        dphase_lock = 1'b1;
        run_until(2, 2000, n);
        check("rstslip_pulse_at", n, 81);
        #2;
        reset = 1'b1;
        #1;
        check("rstslip_bitslip", O_bitslip, 0);
        check("rstslip_loss_cnt", O_loss_cnt, 0);
        check("rstslip_slip_cnt", O_slip_cnt, 0);
        check("rstslip_lock", O_word_lock, 0);
        @(negedge rx_clk);
        reset = 1'b0;
        dphase_lock = 1'b0;
        step();
        check("rstslip_after_bitslip", O_bitslip, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/word_align_ctl.md
# word_align_ctl

Word-boundary alignment controller for the LVDS 7:1 receive path. It starts once the bit-phase alignment controller has locked the sampling phase (`dphase_lock`). It compares the deserialized clock-lane word against the expected clock pattern and issues single-cycle bitslip pulses to the deserializer until the pattern appears unrotated. After lock it monitors the word for loss of alignment and requests a bit-phase re-alignment when the slip range is exhausted.

## Interface
- `RX_CLK_PT`, 7'b1100011, expected unrotated clock-lane word (7'b1100001 for the alternate pattern build).
- `SETTLE_CYC`, 16, cycles to wait after a slip or after entry before sampling; range 1..255.
- `CHECK_CYC`, 64, sample window length in cycles; range 1..1023.
- `LOSS_TH`, 8, consecutive mismatching words in LOCK that declare loss; range 1..255.
- `reset` in 1: asynchronous, active-high; all state and outputs are cleared immediately.
- `rx_clk` in 1: the single clock (deserializer parallel clock).
- `rxclk_word` in 7: deserialized clock-lane word, valid every cycle.
- `dphase_lock` in 1: bit-phase lock from the phase alignment controller; level.
- `O_bitslip` out 1: one-cycle bitslip pulse to the deserializer.
- `O_slip_cnt` out 3: slips issued since the last IDLE, range 0..6.
- `O_word_lock` out 1: word boundary aligned; level.
- `O_realign_req` out 1: request to restart bit-phase alignment; level while in FAIL.
- `O_loss_cnt` out 8: saturating count of LOCK→IDLE loss events since reset.

## Operation
- States: IDLE, SETTLE, CHECK, SLIP, LOCK, FAIL. Reset state is IDLE.
- Global rule: `dphase_lock`=0 in any state except FAIL → IDLE on the next edge. This rule has priority over every other transition. In FAIL, `dphase_lock`=0 is the normal exit to IDLE.
- IDLE: `wait_cnt`, `miss_cnt` and `O_slip_cnt` are cleared. When `dphase_lock`=1 → SETTLE.
- SETTLE:
  - `wait_cnt` counts 0..SETTLE_CYC-1.
  - At SETTLE_CYC-1: clear `wait_cnt` and `miss_cnt` → CHECK.
- CHECK:
  - `wait_cnt` counts 0..CHECK_CYC-1.
  - On every cycle, including the last, `rxclk_word`≠RX_CLK_PT increments `miss_cnt`. `miss_cnt` is 11 bits and saturating.
  - At the last cycle, with the final sample's mismatch included: total misses 0 → LOCK.
  - Otherwise, if `O_slip_cnt`=6 → FAIL.
  - Otherwise → SLIP.
- SLIP:
  - Lasts exactly one cycle, with `O_bitslip`=1.
  - `O_slip_cnt` increments at exit → SETTLE.
- LOCK:
  - `O_word_lock`=1.
  - `run_cnt` counts consecutive mismatching words. Any matching word clears it.
  - `run_cnt` reaches LOSS_TH → IDLE. `O_loss_cnt` increments, saturating at 255.
- FAIL: `O_realign_req`=1. Stays in FAIL until `dphase_lock`=0, then → IDLE.
- Only the unrotated pattern counts as a match. Rotations are resolved by slipping, so at most 6 slips are needed.

## Timing
- All outputs are registered and decoded from the state and next-state registers. Reset value of every output is 0.
- Lock latency with no slip: 1 (IDLE→SETTLE) + SETTLE_CYC + CHECK_CYC cycles from `dphase_lock` rising to `O_word_lock` rising.
- Each slip adds 1 + SETTLE_CYC + CHECK_CYC cycles.
- `O_bitslip` is high for exactly one cycle per SLIP visit. Consecutive pulses are separated by at least SETTLE_CYC + CHECK_CYC low cycles.
- `O_slip_cnt` reflects a slip from the cycle after the pulse.
- `O_word_lock` falls on the cycle IDLE is entered. On a loss event, `O_loss_cnt` updates on that same cycle.
- `O_realign_req` rises on FAIL entry and falls on the cycle IDLE is entered.
- A mismatch on the same cycle that `dphase_lock` falls is ignored, because the priority rule sends the FSM to IDLE.
- Asynchronous reset mid-slip drops `O_bitslip` immediately. No partial pulse is extended.

## Test plan
- **No slip needed.**
  - Stimulus: reset, then `dphase_lock`=1 with a constant `rxclk_word`=7'b1100011; defaults.
  - Response: `O_word_lock` rises 81 cycles after `dphase_lock` rises; `O_bitslip` is never pulsed; `O_slip_cnt`=0.
- **Rotated pattern.**
  - Stimulus: the source word starts rotated by 3, and each `O_bitslip` rotates the model by 1.
  - Response: exactly 4 single-cycle pulses; `O_slip_cnt`=4; lock arrives at 81 + 4·81 = 405 cycles.
- **Exhaustion.**
  - Stimulus: `rxclk_word` is held at 7'b0000000.
  - Response: 6 pulses, then `O_realign_req`=1 with `O_word_lock`=0. After `dphase_lock`→0, `O_realign_req` drops next cycle and `O_slip_cnt` returns to 0.
- **Loss of lock.**
  - Stimulus: in LOCK, inject 7 bad words, then 1 good word, then 8 bad words.
  - Response: no loss after the first burst. After the 8th consecutive bad word, `O_word_lock`=0 and `O_loss_cnt`=1. Re-lock follows automatically.
- **Single miss in CHECK.**
  - Stimulus: in CHECK, a single mismatch on the last window cycle.
  - Response: SLIP is taken, not LOCK.
- **Aborts.**
  - Stimulus: `dphase_lock` deasserted mid-CHECK; separately, `reset` asserted during the SLIP cycle.
  - Response: IDLE is entered next edge with all counters cleared. `reset` forces all outputs to 0 asynchronously.
